// File: rtl/vc_fifo_buffer.sv
// Multi-VC input buffer: NUM_VC circular queues behind one shared write port
// and one shared registered read port, with per-VC status and sticky errors.

module vc_fifo_lane #(
    parameter int NUM_BITS  = 8,
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = 6,
    parameter int CNT_W     = 4,
    parameter int PTR_W     = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_push,
    input  logic                i_pop,
    input  logic [NUM_BITS-1:0] i_data,
    output logic [NUM_BITS-1:0] o_head,
    output logic [CNT_W-1:0]    o_count,
    output logic                o_empty,
    output logic                o_full,
    output logic                o_afull
);
    logic [NUM_BITS-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;

    // Storage carries no reset; only pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (i_push)
            r_mem[r_wr_ptr] <= i_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push)
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (i_pop)
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_afull = (r_count >= CNT_W'(AF_THRESH));
endmodule

module vc_fifo_buffer #(
    parameter int NUM_BITS  = 8,
    parameter int DEPTH     = 8,
    parameter int NUM_VC    = 2,
    parameter int AF_THRESH = 6,
    localparam int VC_W     = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
    localparam int CNT_W    = $clog2(DEPTH) + 1,
    localparam int PTR_W    = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [VC_W-1:0]         wr_vc,
    input  logic [NUM_BITS-1:0]     fifo_in,
    input  logic                    rd_en,
    input  logic [VC_W-1:0]         rd_vc,
    output logic [NUM_BITS-1:0]     fifo_out,
    output logic                    out_valid,
    output logic [VC_W-1:0]         out_vc,
    output logic [NUM_VC-1:0]       empty,
    output logic [NUM_VC-1:0]       full,
    output logic [NUM_VC-1:0]       almost_full,
    output logic [NUM_VC*CNT_W-1:0] fifo_counter,
    input  logic                    err_clr,
    output logic                    ovf_err,
    output logic                    udf_err
);
    logic [NUM_VC-1:0]               w_push;
    logic [NUM_VC-1:0]               w_pop;
    logic [NUM_VC-1:0][NUM_BITS-1:0] w_head;
    logic [NUM_VC-1:0][CNT_W-1:0]    w_cnt;
    logic                            w_wa;
    logic                            w_ra;
    logic [NUM_BITS-1:0]             w_rd_data;

    logic [NUM_BITS-1:0] r_fifo_out;
    logic                r_out_valid;
    logic [VC_W-1:0]     r_out_vc;
    logic                r_ovf_err;
    logic                r_udf_err;

    // An out-of-range VC id matches no lane, so it is rejected like a full/empty hit.
    for (genvar v = 0; v < NUM_VC; v++) begin : g_lane
        assign w_push[v] = wr_en && (wr_vc == VC_W'(v)) && !full[v];
        assign w_pop[v]  = rd_en && (rd_vc == VC_W'(v)) && !empty[v];

        vc_fifo_lane #(
            .NUM_BITS  (NUM_BITS),
            .DEPTH     (DEPTH),
            .AF_THRESH (AF_THRESH),
            .CNT_W     (CNT_W),
            .PTR_W     (PTR_W)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_push  (w_push[v]),
            .i_pop   (w_pop[v]),
            .i_data  (fifo_in),
            .o_head  (w_head[v]),
            .o_count (w_cnt[v]),
            .o_empty (empty[v]),
            .o_full  (full[v]),
            .o_afull (almost_full[v])
        );

        assign fifo_counter[v*CNT_W +: CNT_W] = w_cnt[v];
    end

    assign w_wa = |w_push;
    assign w_ra = |w_pop;

    always_comb begin
        w_rd_data = '0;
        for (int v = 0; v < NUM_VC; v++)
            if (w_pop[v])
                w_rd_data = w_head[v];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fifo_out  <= '0;
            r_out_valid <= 1'b0;
            r_out_vc    <= '0;
        end else begin
            r_out_valid <= w_ra;
            if (w_ra) begin
                r_fifo_out <= w_rd_data;
                r_out_vc   <= rd_vc;
            end
        end
    end

    // A new error in the same cycle as err_clr takes priority over the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf_err <= 1'b0;
            r_udf_err <= 1'b0;
        end else begin
            if (wr_en && !w_wa)
                r_ovf_err <= 1'b1;
            else if (err_clr)
                r_ovf_err <= 1'b0;
            if (rd_en && !w_ra)
                r_udf_err <= 1'b1;
            else if (err_clr)
                r_udf_err <= 1'b0;
        end
    end

    assign fifo_out  = r_fifo_out;
    assign out_valid = r_out_valid;
    assign out_vc    = r_out_vc;
    assign ovf_err   = r_ovf_err;
    assign udf_err   = r_udf_err;
endmodule

// File: tb/tb_vc_fifo_buffer.sv
// Bench for vc_fifo_buffer: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.

module tb_vc_fifo_buffer;
    logic       clk;
    logic       rst_n;
    logic       wr_en;
    logic [0:0] wr_vc;
    logic [7:0] fifo_in;
    logic       rd_en;
    logic [0:0] rd_vc;
    logic [7:0] fifo_out;
    logic       out_valid;
    logic [0:0] out_vc;
    logic [1:0] empty;
    logic [1:0] full;
    logic [1:0] almost_full;
    logic [7:0] fifo_counter;
    logic       err_clr;
    logic       ovf_err;
    logic       udf_err;

    int n_cmp = 0;
    int n_bad = 0;

    vc_fifo_buffer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wr_vc        (wr_vc),
        .fifo_in      (fifo_in),
        .rd_en        (rd_en),
        .rd_vc        (rd_vc),
        .fifo_out     (fifo_out),
        .out_valid    (out_valid),
        .out_vc       (out_vc),
        .empty        (empty),
        .full         (full),
        .almost_full  (almost_full),
        .fifo_counter (fifo_counter),
        .err_clr      (err_clr),
        .ovf_err      (ovf_err),
        .udf_err      (udf_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endfunction

    // Reference model: one FIFO queue per VC, decisions from pre-edge occupancy.
    logic [7:0] q [2][$];
    logic [7:0] exp_out;
    logic       exp_vld;
    logic [0:0] exp_vc;
    logic       exp_ovf;
    logic       exp_udf;

    always @(posedge clk or negedge rst_n) begin
        bit wa, ra;
        if (!rst_n) begin
            q[0].delete();
            q[1].delete();
            exp_out = 8'h00;
            exp_vld = 1'b0;
            exp_vc  = 1'b0;
            exp_ovf = 1'b0;
            exp_udf = 1'b0;
        end else begin
            wa = wr_en && (q[wr_vc].size() < 8);
            ra = rd_en && (q[rd_vc].size() > 0);
            exp_vld = ra;
            if (ra) begin
                exp_out = q[rd_vc].pop_front();
                exp_vc  = rd_vc;
            end
            if (wa)
                q[wr_vc].push_back(fifo_in);
            if (wr_en && !wa) exp_ovf = 1'b1;
            else if (err_clr) exp_ovf = 1'b0;
            if (rd_en && !ra) exp_udf = 1'b1;
            else if (err_clr) exp_udf = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("counter", fifo_counter, {4'(q[1].size()), 4'(q[0].size())});
            check("empty", empty, {q[1].size() == 0, q[0].size() == 0});
            check("full", full, {q[1].size() == 8, q[0].size() == 8});
            check("almost_full", almost_full, {q[1].size() >= 6, q[0].size() >= 6});
            check("out_valid", out_valid, exp_vld);
            check("fifo_out", fifo_out, exp_out);
            check("out_vc", out_vc, exp_vc);
            check("ovf_err", ovf_err, exp_ovf);
            check("udf_err", udf_err, exp_udf);
        end
    end

    task automatic cyc(input logic we, input logic [0:0] wv, input logic [7:0] d,
                       input logic re, input logic [0:0] rv, input logic ec);
        wr_en = we; wr_vc = wv; fifo_in = d;
        rd_en = re; rd_vc = rv; err_clr = ec;
        @(posedge clk);
        #1;
        wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
    endtask

    task automatic wr(input logic [0:0] v, input logic [7:0] d);
        cyc(1'b1, v, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rd(input logic [0:0] v);
        cyc(1'b0, 1'b0, 8'h00, 1'b1, v, 1'b0);
    endtask

    task automatic clr();
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        rst_n = 1'b1; wr_en = 1'b0; wr_vc = 1'b0; fifo_in = 8'h00;
        rd_en = 1'b0; rd_vc = 1'b0; err_clr = 1'b0;

        // Asynchronous reset between clock edges
        #3 rst_n = 1'b0;
        #1;
        check("rst empty", empty, 2'b11);
        check("rst full", full, 2'b00);
        check("rst counter", fifo_counter, 8'h00);
        check("rst out_valid", out_valid, 1'b0);
        check("rst fifo_out", fifo_out, 8'h00);
        check("rst errs", {ovf_err, udf_err}, 2'b00);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // VC0 fill
        for (int i = 1; i <= 8; i++) begin
            wr(1'b0, 8'(i));
            if (i == 5) check("af after 5", almost_full[0], 1'b0);
            if (i == 6) check("af after 6", almost_full[0], 1'b1);
        end
        check("fill count0", fifo_counter[3:0], 4'd8);
        check("fill full0", full[0], 1'b1);
        wr(1'b0, 8'h09);
        check("9th write ovf", ovf_err, 1'b1);
        check("9th write count0", fifo_counter[3:0], 4'd8);
        clr();
        check("clr ovf", ovf_err, 1'b0);

        // VC0 drain
        for (int i = 1; i <= 8; i++) begin
            rd(1'b0);
            check("drain data", fifo_out, 8'(i));
            check("drain vld/vc", {out_valid, out_vc}, 2'b10);
        end
        rd(1'b0);
        check("9th read udf", udf_err, 1'b1);
        check("9th read vld", out_valid, 1'b0);
        check("9th read hold", fifo_out, 8'h08);
        clr();

        // Interleaved VCs
        wr(1'b0, 8'hA0);
        wr(1'b1, 8'hB0);
        wr(1'b0, 8'hA1);
        rd(1'b1);
        check("ilv B0", {out_vc, fifo_out}, 9'h1B0);
        rd(1'b0);
        check("ilv A0", {out_vc, fifo_out}, 9'h0A0);
        rd(1'b0);
        check("ilv A1", {out_vc, fifo_out}, 9'h0A1);

        // Simultaneous push/pop, count 3
        wr(1'b0, 8'h31); wr(1'b0, 8'h32); wr(1'b0, 8'h33);
        cyc(1'b1, 1'b0, 8'h34, 1'b1, 1'b0, 1'b0);
        check("rw3 data", fifo_out, 8'h31);
        check("rw3 count0", fifo_counter[3:0], 4'd3);
        for (int i = 0; i < 3; i++) rd(1'b0);
        check("rw3 last", fifo_out, 8'h34);

        // Simultaneous push/pop, VC0 full
        for (int i = 0; i < 8; i++) wr(1'b0, 8'(8'h40 + i));
        cyc(1'b1, 1'b0, 8'h48, 1'b1, 1'b0, 1'b0);
        check("rwfull data", fifo_out, 8'h40);
        check("rwfull ovf", ovf_err, 1'b1);
        check("rwfull count0", fifo_counter[3:0], 4'd7);
        clr();
        for (int i = 0; i < 7; i++) rd(1'b0);
        check("rwfull last", fifo_out, 8'h47);

        // Simultaneous push/pop, VC0 empty
        cyc(1'b1, 1'b0, 8'h55, 1'b1, 1'b0, 1'b0);
        check("rwempty udf", udf_err, 1'b1);
        check("rwempty vld", out_valid, 1'b0);
        check("rwempty count0", fifo_counter[3:0], 4'd1);
        rd(1'b0);
        check("rwempty data", fifo_out, 8'h55);
        clr();

        // Wrap-around on VC1
        wr(1'b1, 8'h60);
        for (int i = 1; i <= 20; i++) begin
            cyc(1'b1, 1'b1, 8'(8'h60 + i), 1'b1, 1'b1, 1'b0);
            check("wrap data", fifo_out, 8'(8'h60 + i - 1));
        end
        rd(1'b1);
        check("wrap last", fifo_out, 8'h74);
        check("wrap count1", fifo_counter[7:4], 4'd0);

        // Reset mid-operation
        for (int i = 0; i < 5; i++) wr(1'b0, 8'(8'h80 + i));
        check("pre-rst count0", fifo_counter[3:0], 4'd5);
        #3 rst_n = 1'b0;
        #1;
        check("midrst count0", fifo_counter[3:0], 4'd0);
        check("midrst empty", empty, 2'b11);
        check("midrst fifo_out", fifo_out, 8'h00);
        @(posedge clk);
        #1 rst_n = 1'b1;
        rd(1'b0);
        check("post-rst udf", udf_err, 1'b1);

        // err_clr together with a new overflow
        for (int i = 0; i < 8; i++) wr(1'b1, 8'(8'h90 + i));
        cyc(1'b1, 1'b1, 8'h98, 1'b0, 1'b0, 1'b1);
        check("clr+ovf", ovf_err, 1'b1);
        check("clr+ovf udf", udf_err, 1'b0);
        clr();
        check("clr alone", ovf_err, 1'b0);

        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
